antifurto_timer: RTL and testbench
==================================

// Module: antifurto_timer
// PURPOSE
//  Time base and countdown timer for the anti-theft controller FSM. Consumes the FSM's start_timer/interval
//  request and returns the expired pulse plus the 1 Hz enable it uses for status blinking.
//  Holds the four user-programmable delays (arm, driver door, passenger door, alarm-on); sits between the
//  switch/keypad reprogram inputs and the FSM, and drives the seconds display.
// PARAMETERS
//  CLK_FREQ_HZ    50_000_000  clock cycles per second; the prescaler divides by this (min 2)
//  DEF_T_ARM      4'd6        reset value of T_ARM_DELAY (s), selected by interval=2'b00
//  DEF_T_DRIVER   4'd8        reset value of T_DRIVER_DELAY (s), interval=2'b01
//  DEF_T_PASS     4'd15       reset value of T_PASSENGER_DELAY (s), interval=2'b10
//  DEF_T_ALARM    4'd10       reset value of T_ALARM_ON (s), interval=2'b11
// PORTS
//  clock           in   1  system clock; all state changes on its rising edge
//  reset_n         in   1  asynchronous active-low reset
//  start_timer     in   1  sampled each edge; high = (re)start countdown with interval
//  interval        in   2  delay select, valid when start_timer=1
//  reprogram       in   1  high = write time_value into delay time_param_sel this edge
//  time_param_sel  in   2  delay to write (same encoding as interval)
//  time_value      in   4  new delay in seconds, 0..15
//  expired         out  1  one-cycle pulse when the countdown reaches zero
//  one_hz_enable   out  1  one-cycle pulse once every CLK_FREQ_HZ cycles
//  busy            out  1  high while a countdown is in progress
//  remaining       out  4  seconds left in current countdown (0 when idle)
// BEHAVIOUR
//  - Reset (async, reset_n=0): delays <= DEF_*; prescaler, remaining <= 0; expired, one_hz_enable, busy <= 0;
//    state <= IDLE. Takes effect mid-countdown with no expired pulse. All outputs registered.
//  - Prescaler: $clog2(CLK_FREQ_HZ)-bit free-running counter 0..CLK_FREQ_HZ-1, wraps to 0; one_hz_enable is 1
//    for exactly the cycle after the counter holds CLK_FREQ_HZ-1. Prescaler clears to 0 on an accepted start.
//  - FSM states: IDLE, COUNT, EXPIRE.
//    IDLE  : start_timer=1 -> remaining <= delay[interval]; COUNT if value!=0 else EXPIRE.
//    COUNT : busy=1; each one_hz_enable, remaining <= remaining-1; on 1->0 go EXPIRE.
//    EXPIRE: expired=1 for this single cycle, busy=0, remaining=0; next IDLE (or COUNT/EXPIRE if start_timer=1).
//  - Latency: expired is high in cycle N+max(1,V*CLK_FREQ_HZ), where N = edge that sampled start_timer and
//    V = selected delay. No extra cycles; the V=0 case gives expired one cycle after start.
//  - start_timer in COUNT: restart with new interval value, prescaler cleared; aborted run gives no expired.
//  - start_timer on the edge remaining would reach 0: restart wins; no expired.
//  - reprogram=1: delay[time_param_sel] <= time_value; any countdown aborted (-> IDLE, busy=0, remaining=0,
//    no expired). reprogram has priority over start_timer in the same cycle (start ignored).
//  - Writing the delay currently counting only affects later starts (covered by abort above).
//  - remaining never underflows; arithmetic is unsigned 4-bit.
// CONFIGURATION
//  TIMER_READBACK_EN defined: adds output port param_readback [3:0] = delay[time_param_sel]. This is
//   combinational from registered delays and reflects a write on the cycle after the reprogram edge.
//  TIMER_READBACK_EN undefined: port absent; no readback mux; all other behaviour identical.
// TESTING (bench uses CLK_FREQ_HZ=4)
//  1 reset_n=0 then 1 -> all outputs 0; start, interval=01 -> expired single pulse at N+32, busy high N+1..N+31.
//  2 idle, no start -> one_hz_enable pulses every 4 cycles, exactly one cycle wide, never while reset_n=0.
//  3 reprogram sel=11 value=3, then start interval=11 -> expired at N+12; reprogram value=0, start -> expired N+1.
//  4 start interval=10 (15 s), at N+20 start interval=00 (M) -> remaining reloads 6, expired only at M+24.
//  5 reprogram during COUNT -> busy=0 next cycle, no expired; start+reprogram same cycle -> stays IDLE.
//  6 reset_n pulled low mid-COUNT (async, between edges) -> busy/remaining 0 immediately, delays back to DEF_*.

Source files
------------

// File: rtl/antifurto_timer.sv
// Time base and countdown timer for the anti-theft controller: 1 Hz prescaler, four programmable delays.
// Define TIMER_READBACK_EN to add o_param_readback = delay[i_time_param_sel].
module antifurto_timer #(
    parameter int       CLK_FREQ_HZ  = 50_000_000,
    parameter bit [3:0] DEF_T_ARM    = 4'd6,
    parameter bit [3:0] DEF_T_DRIVER = 4'd8,
    parameter bit [3:0] DEF_T_PASS   = 4'd15,
    parameter bit [3:0] DEF_T_ALARM  = 4'd10
) (
    input  logic       i_clock,
    input  logic       i_reset_n,
    input  logic       i_start_timer,
    input  logic [1:0] i_interval,
    input  logic       i_reprogram,
    input  logic [1:0] i_time_param_sel,
    input  logic [3:0] i_time_value,
    output logic       o_expired,
    output logic       o_one_hz_enable,
    output logic       o_busy,
    output logic [3:0] o_remaining
`ifdef TIMER_READBACK_EN
    ,
    output logic [3:0] o_param_readback
`endif
);

    // state  | meaning
    // IDLE   | no countdown; remaining = 0
    // COUNT  | counting down on each prescaler wrap; a zero load expires on the next edge
    // EXPIRE | the single cycle in which expired is high
    typedef enum logic [1:0] {IDLE, COUNT, EXPIRE} state_t;

    localparam int             PW        = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
    localparam logic [PW-1:0]  PRESC_MAX = PW'(CLK_FREQ_HZ - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [PW-1:0] r_presc;
    logic [3:0]    r_delay [0:3];
    logic [3:0]    r_remaining;
    logic [3:0]    w_rem_nxt;
    logic [3:0]    w_sel_delay;
    logic          w_tick;
    logic          w_start;

    assign w_tick      = (r_presc == PRESC_MAX);
    assign w_start     = i_start_timer & ~i_reprogram;
    assign w_sel_delay = r_delay[i_interval];
    assign o_remaining = r_remaining;

`ifdef TIMER_READBACK_EN
    assign o_param_readback = r_delay[i_time_param_sel];
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_remaining;
        if (i_reprogram) begin
            w_state_nxt = IDLE;
            w_rem_nxt   = 4'd0;
        end else if (i_start_timer) begin
            w_state_nxt = COUNT;
            w_rem_nxt   = w_sel_delay;
        end else begin
            case (r_state)
                COUNT: begin
                    if (r_remaining == 4'd0) begin
                        w_state_nxt = EXPIRE;
                    end else if (w_tick) begin
                        w_rem_nxt = r_remaining - 4'd1;
                        if (r_remaining == 4'd1) begin
                            w_state_nxt = EXPIRE;
                        end
                    end
                end
                EXPIRE:  w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state         <= IDLE;
            r_presc         <= '0;
            r_remaining     <= 4'd0;
            r_delay[0]      <= DEF_T_ARM;
            r_delay[1]      <= DEF_T_DRIVER;
            r_delay[2]      <= DEF_T_PASS;
            r_delay[3]      <= DEF_T_ALARM;
            o_expired       <= 1'b0;
            o_one_hz_enable <= 1'b0;
            o_busy          <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_rem_nxt;
            if (w_start || w_tick) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
            if (i_reprogram) begin
                r_delay[i_time_param_sel] <= i_time_value;
            end
            o_one_hz_enable <= w_tick;
            o_expired       <= (w_state_nxt == EXPIRE);
            // busy drops on the edge that enters EXPIRE, and rises one cycle after a start from IDLE
            o_busy          <= (r_state == COUNT) && (w_state_nxt == COUNT);
        end
    end

endmodule

// File: tb/tb_antifurto_timer.sv
// Self-checking bench for antifurto_timer with CLK_FREQ_HZ=4: directed table, corner sequences, random vs model.
module tb_antifurto_timer;
    localparam int F = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       st = 1'b0;
    logic [1:0] iv = 2'd0;
    logic       rp = 1'b0;
    logic [1:0] sel = 2'd0;
    logic [3:0] val = 4'd0;
    logic       exp_o, one_o, busy_o;
    logic [3:0] rem_o;
`ifdef TIMER_READBACK_EN
    logic [3:0] rb_o;
`endif

    antifurto_timer #(.CLK_FREQ_HZ(F)) dut (
        .i_clock(clk), .i_reset_n(rst_n), .i_start_timer(st), .i_interval(iv),
        .i_reprogram(rp), .i_time_param_sel(sel), .i_time_value(val),
        .o_expired(exp_o), .o_one_hz_enable(one_o), .o_busy(busy_o), .o_remaining(rem_o)
`ifdef TIMER_READBACK_EN
        , .o_param_readback(rb_o)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: runs are described by start edge, deadline and loaded value
    int         k = 0;
    int         c = 0;
    int         run_n, run_d, run_v;
    bit         counting = 0;
    logic [3:0] dly [4];
    logic       e_exp, e_one, e_busy;
    logic [3:0] e_rem;

    typedef struct {
        logic       st;
        logic [1:0] iv;
        logic       rp;
        logic [1:0] sel;
        logic [3:0] val;
        logic       x_exp;
        logic       x_one;
        logic       x_busy;
        logic [3:0] x_rem;
    } vec_t;
    vec_t tbl [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", nm, k, act, req);
        end
    endtask

    task automatic model_reset();
        dly[0] = 4'd6; dly[1] = 4'd8; dly[2] = 4'd15; dly[3] = 4'd10;
        counting = 0;
        c = k;
    endtask

    task automatic model_step(input logic s, input logic [1:0] i, input logic r,
                              input logic [1:0] ps, input logic [3:0] v);
        bit prev;
        int pb;
        pb     = (k - 1 - c) % F;
        e_one  = (pb == F - 1);
        prev   = counting;
        e_exp  = 1'b0;
        e_busy = 1'b0;
        e_rem  = 4'd0;
        if (r) begin
            dly[ps]  = v;
            counting = 0;
        end else if (s) begin
            run_v    = int'(dly[i]);
            run_n    = k;
            run_d    = k + ((run_v == 0) ? 1 : run_v * F);
            counting = 1;
            c        = k;
            e_busy   = prev;
            e_rem    = 4'(run_v);
        end else if (counting) begin
            if (k == run_d) begin
                e_exp    = 1'b1;
                counting = 0;
            end else begin
                e_busy = 1'b1;
                e_rem  = 4'(run_v - (k - run_n) / F);
            end
        end
    endtask

    task automatic chk_model();
        chk("expired", exp_o, e_exp);
        chk("one_hz", one_o, e_one);
        chk("busy", busy_o, e_busy);
        chk("remaining", rem_o, e_rem);
`ifdef TIMER_READBACK_EN
        chk("readback", rb_o, dly[sel]);
`endif
    endtask

    task automatic cyc(input logic s, input logic [1:0] i, input logic r,
                       input logic [1:0] ps, input logic [3:0] v, input bit check);
        st = s; iv = i; rp = r; sel = ps; val = v;
        @(posedge clk);
        k++;
        model_step(s, i, r, ps, v);
        #1;
        if (check) chk_model();
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) cyc(1'b0, 2'd0, 1'b0, 2'd0, 4'd0, 1'b1);
    endtask

    // Async reset asserted between edges: outputs must clear without waiting for a clock
    task automatic do_reset();
        #2;
        rst_n = 1'b0; st = 1'b0; rp = 1'b0;
        #1;
        model_reset();
        chk("rst_expired", exp_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_remaining", rem_o, 4'd0);
        chk("rst_one_hz", one_o, 1'b0);
        for (int j = 0; j < 3; j++) begin
            @(posedge clk);
            k++;
            c = k;
            #1;
            chk("rst_one_hz_held", one_o, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_expired(input string nm, input int want, input int bound);
        int  n0;
        bit  seen;
        n0   = k;
        seen = 0;
        for (int j = 0; j < bound && !seen; j++) begin
            cyc(1'b0, 2'd0, 1'b0, 2'd0, 4'd0, 1'b1);
            if (exp_o === 1'b1) seen = 1;
        end
        chk(nm, seen ? (k - n0) : -1, want - 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //            st   iv    rp   sel   val    exp  one  busy rem
        tbl[0]  = '{1'b0, 2'd0, 1'b1, 2'd3, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[1]  = '{1'b1, 2'd3, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[2]  = '{1'b0, 2'd0, 1'b0, 2'd0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0};
        tbl[3]  = '{1'b1, 2'd0, 1'b1, 2'd0, 4'd2, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[4]  = '{1'b1, 2'd0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd2};
        tbl[5]  = '{1'b0, 2'd0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd2};
        tbl[6]  = '{1'b0, 2'd0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd2};
        tbl[7]  = '{1'b0, 2'd0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd2};
        tbl[8]  = '{1'b0, 2'd0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd1};
        tbl[9]  = '{1'b0, 2'd0, 1'b1, 2'd1, 4'd5, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[10] = '{1'b0, 2'd0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[11] = '{1'b0, 2'd0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[12] = '{1'b0, 2'd0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0};
        tbl[13] = '{1'b1, 2'd1, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd5};

        model_reset();
        do_reset();

        for (int i = 0; i < 14; i++) begin
            cyc(tbl[i].st, tbl[i].iv, tbl[i].rp, tbl[i].sel, tbl[i].val, 1'b0);
            chk($sformatf("tbl%0d_expired", i), exp_o, tbl[i].x_exp);
            chk($sformatf("tbl%0d_one_hz", i), one_o, tbl[i].x_one);
            chk($sformatf("tbl%0d_busy", i), busy_o, tbl[i].x_busy);
            chk($sformatf("tbl%0d_remaining", i), rem_o, tbl[i].x_rem);
        end

        // driver delay from reset: 8 s -> 32 cycles, then idle one_hz cadence
        do_reset();
        cyc(1'b1, 2'd1, 1'b0, 2'd0, 4'd0, 1'b1);
        wait_expired("t1_latency", 32, 40);
        idle(12);

        // reprogrammed alarm delay 3 s, then 0 s
        cyc(1'b0, 2'd0, 1'b1, 2'd3, 4'd3, 1'b1);
        cyc(1'b1, 2'd3, 1'b0, 2'd0, 4'd0, 1'b1);
        wait_expired("t3_latency3", 12, 20);
        cyc(1'b0, 2'd0, 1'b1, 2'd3, 4'd0, 1'b1);
        cyc(1'b1, 2'd3, 1'b0, 2'd0, 4'd0, 1'b1);
        wait_expired("t3_latency0", 1, 4);

        // restart mid-count with the arm delay
        cyc(1'b1, 2'd2, 1'b0, 2'd0, 4'd0, 1'b1);
        idle(19);
        cyc(1'b1, 2'd0, 1'b0, 2'd0, 4'd0, 1'b1);
        chk("t4_reload", rem_o, 4'd6);
        wait_expired("t4_latency", 24, 30);

        // reprogram aborts a run; start+reprogram together stays idle
        cyc(1'b1, 2'd1, 1'b0, 2'd0, 4'd0, 1'b1);
        idle(6);
        cyc(1'b0, 2'd0, 1'b1, 2'd2, 4'd4, 1'b1);
        idle(40);
        cyc(1'b1, 2'd0, 1'b1, 2'd0, 4'd1, 1'b1);
        idle(6);

        // start on the same edge the count would reach zero
        cyc(1'b1, 2'd0, 1'b0, 2'd0, 4'd0, 1'b1);
        idle(3);
        cyc(1'b1, 2'd3, 1'b0, 2'd0, 4'd0, 1'b1);
        idle(4);

        // async reset mid-count restores defaults
        cyc(1'b1, 2'd2, 1'b0, 2'd0, 4'd0, 1'b1);
        idle(10);
        do_reset();
        cyc(1'b1, 2'd0, 1'b0, 2'd0, 4'd0, 1'b1);
        wait_expired("t6_default_arm", 24, 30);

        for (int i = 0; i < 2500; i++) begin
            cyc(($urandom_range(0, 11) == 0), 2'($urandom_range(0, 3)),
                ($urandom_range(0, 29) == 0), 2'($urandom_range(0, 3)),
                4'($urandom_range(0, 4)), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
